// File: rtl/mlsu_req_arbiter.sv
// mlsu_req_arbiter
//   Round-robin arbiter that funnels NrReq load/store requesters onto the single
//   MLSU request port. A one-entry output register holds the granted payload
//   until the control machine accepts it. Accepted-but-uncompleted stores are
//   counted so that stores can be throttled at MaxStOutstanding and loads can
//   optionally wait for all outstanding stores to drain.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   req_valid_i         per-requester request valid
//   req_ready_o         per-requester one-cycle accept pulse (at most one bit set)
//   req_i               per-requester payload
//   req_is_store_i      per-requester 1 = store, 0 = load
//   order_en_i          1 = loads wait until no store is outstanding
//   mlsu_req_valid_o    held request valid towards the control machine
//   mlsu_req_ready_i    control machine accepts the held request
//   mlsu_req_o          registered payload of the held request
//   st_done_i           one-cycle pulse: one store fully completed
//   core_st_pending_o   outstanding store count is non-zero
//   st_cnt_o            outstanding store count
//   err_o               sticky: st_done_i arrived with nothing outstanding
module mlsu_req_arbiter #(
   parameter int  NrReq            = 2,
   parameter int  MaxStOutstanding = 8,
   parameter type mlsu_init_req_t  = logic
) (
   input  logic                                        clk_i,
   input  logic                                        rst_i,
   input  logic [NrReq-1:0]                            req_valid_i,
   output logic [NrReq-1:0]                            req_ready_o,
   input  mlsu_init_req_t                              req_i [NrReq-1:0],
   input  logic [NrReq-1:0]                            req_is_store_i,
   input  logic                                        order_en_i,
   output logic                                        mlsu_req_valid_o,
   input  logic                                        mlsu_req_ready_i,
   output mlsu_init_req_t                              mlsu_req_o,
   input  logic                                        st_done_i,
   output logic                                        core_st_pending_o,
   output logic [$clog2(MaxStOutstanding+1)-1:0]       st_cnt_o,
   output logic                                        err_o
);

   localparam int IdxW = (NrReq > 1) ? $clog2(NrReq) : 1;
   localparam int CntW = $clog2(MaxStOutstanding + 1);
   localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxStOutstanding);
   localparam logic [IdxW:0]   NrReqW  = (IdxW+1)'(NrReq);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [CntW-1:0]     st_cnt_q, st_cnt_d;
   logic                err_q, err_d;
   mlsu_init_req_t      mlsu_req_q, mlsu_req_d;

   logic [NrReq-1:0]    eligible;
   logic [2*NrReq-1:0]  elig_dbl;
   logic                found;
   logic [IdxW:0]       offset;
   logic [IdxW:0]       win_sum;
   logic [IdxW:0]       next_sum;
   logic [IdxW-1:0]     winner;
   logic [IdxW-1:0]     rr_next;
   logic                store_room;
   logic                load_ok;
   logic                st_inc;

   // Eligibility uses the count as it stands this cycle, before any update.
   always_comb begin
      store_room = (st_cnt_q < MaxCnt);
      load_ok    = ~order_en_i | (st_cnt_q == {CntW{1'b0}});
      for (int i = 0; i < NrReq; i++) begin
         eligible[i] = req_valid_i[i] & (req_is_store_i[i] ? store_room : load_ok);
      end
   end

   // Round-robin search: rotate so rr_ptr sits at bit 0, take the lowest set bit,
   // then map the offset back to an absolute requester index.
   always_comb begin
      elig_dbl = {eligible, eligible} >> rr_ptr_q;
      found    = 1'b0;
      offset   = {(IdxW+1){1'b0}};
      for (int k = 0; k < NrReq; k++) begin
         offset = (!found && elig_dbl[k]) ? (IdxW+1)'(k) : offset;
         found  = found | elig_dbl[k];
      end
      win_sum  = {1'b0, rr_ptr_q} + offset;
      winner   = IdxW'((win_sum >= NrReqW) ? (win_sum - NrReqW) : win_sum);
      next_sum = {1'b0, winner} + (IdxW+1)'(1);
      rr_next  = IdxW'((next_sum == NrReqW) ? {(IdxW+1){1'b0}} : next_sum);
   end

   // Grant / hold state machine next-state; accept pulse is suppressed in reset.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      mlsu_req_d  = mlsu_req_q;
      req_ready_o = {NrReq{1'b0}};
      st_inc      = 1'b0;
      case (state_q)
         IDLE: begin
            if (found && !rst_i) begin
               req_ready_o[winner] = 1'b1;
               mlsu_req_d          = req_i[winner];
               st_inc              = req_is_store_i[winner];
               state_d             = HOLD;
               rr_ptr_d            = rr_next;
            end else begin
               state_d = IDLE;
            end
         end
         HOLD: begin
            if (mlsu_req_ready_i) begin
               state_d = IDLE;
            end else begin
               state_d = HOLD;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outstanding store counter; a decrement with nothing outstanding flags err.
   always_comb begin
      st_cnt_d = st_cnt_q;
      err_d    = err_q;
      if (st_inc && !st_done_i) begin
         st_cnt_d = st_cnt_q + CntW'(1);
      end else if (!st_inc && st_done_i) begin
         if (st_cnt_q != {CntW{1'b0}}) begin
            st_cnt_d = st_cnt_q - CntW'(1);
         end else begin
            err_d = 1'b1;
         end
      end else begin
         st_cnt_d = st_cnt_q;
      end
   end

   // State, pointer, counter and payload registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         rr_ptr_q   <= {IdxW{1'b0}};
         st_cnt_q   <= {CntW{1'b0}};
         err_q      <= 1'b0;
         mlsu_req_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         st_cnt_q   <= st_cnt_d;
         err_q      <= err_d;
         mlsu_req_q <= mlsu_req_d;
      end
   end

   assign mlsu_req_valid_o  = (state_q == HOLD);
   assign mlsu_req_o        = mlsu_req_q;
   assign st_cnt_o          = st_cnt_q;
   assign core_st_pending_o = (st_cnt_q != {CntW{1'b0}});
   assign err_o             = err_q;

endmodule

// File: tb/tb_mlsu_req_arbiter.sv
`timescale 1ns/1ps
module tb_mlsu_req_arbiter;
   localparam int N     = 2;
   localparam int MAXST = 2;
   typedef logic [7:0] pay_t;

   logic          clk = 1'b0;
   logic          rst_i;
   logic [N-1:0]  req_valid_i;
   logic [N-1:0]  req_ready_o;
   pay_t          req_i [N-1:0];
   logic [N-1:0]  req_is_store_i;
   logic          order_en_i;
   logic          mlsu_req_valid_o;
   logic          mlsu_req_ready_i;
   pay_t          mlsu_req_o;
   logic          st_done_i;
   logic          core_st_pending_o;
   logic [1:0]    st_cnt_o;
   logic          err_o;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   pay_t sb[$];
   int   m_ptr  = 0;
   int   m_cnt  = 0;
   bit   m_busy = 1'b0;
   bit   m_err  = 1'b0;

   mlsu_req_arbiter #(
      .NrReq            (N),
      .MaxStOutstanding (MAXST),
      .mlsu_init_req_t  (pay_t)
   ) dut (
      .clk_i             (clk),
      .rst_i             (rst_i),
      .req_valid_i       (req_valid_i),
      .req_ready_o       (req_ready_o),
      .req_i             (req_i),
      .req_is_store_i    (req_is_store_i),
      .order_en_i        (order_en_i),
      .mlsu_req_valid_o  (mlsu_req_valid_o),
      .mlsu_req_ready_i  (mlsu_req_ready_i),
      .mlsu_req_o        (mlsu_req_o),
      .st_done_i         (st_done_i),
      .core_st_pending_o (core_st_pending_o),
      .st_cnt_o          (st_cnt_o),
      .err_o             (err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic bit elig(input int i);
      if (!req_valid_i[i]) return 1'b0;
      if (req_is_store_i[i]) return (m_cnt < MAXST);
      return (!order_en_i) || (m_cnt == 0);
   endfunction

   task automatic model_reset();
      m_ptr  = 0;
      m_cnt  = 0;
      m_busy = 1'b0;
      m_err  = 1'b0;
      sb.delete();
   endtask

   // Compare DUT against the model for the current cycle, then advance the model
   // to what it should be after the coming clock edge.
   task automatic model_step();
      int win;
      int idx;
      logic [N-1:0] exp_rdy;
      bit inc;
      if (rst_i) begin
         chk("rst_ready",   32'(req_ready_o),       32'd0);
         chk("rst_valid",   32'(mlsu_req_valid_o),  32'd0);
         chk("rst_payload", 32'(mlsu_req_o),        32'd0);
         chk("rst_cnt",     32'(st_cnt_o),          32'd0);
         chk("rst_err",     32'(err_o),             32'd0);
         chk("rst_pending", 32'(core_st_pending_o), 32'd0);
         model_reset();
      end else begin
         chk("valid",   32'(mlsu_req_valid_o),  32'(m_busy));
         chk("st_cnt",  32'(st_cnt_o),          32'(m_cnt));
         chk("pending", 32'(core_st_pending_o), 32'(m_cnt != 0));
         chk("err",     32'(err_o),             32'(m_err));
         win = -1;
         if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
               idx = (m_ptr + k) % N;
               if (win < 0 && elig(idx)) win = idx;
            end
         end
         exp_rdy = (win >= 0) ? (N'(1) << win) : N'(0);
         chk("grant", 32'(req_ready_o), 32'(exp_rdy));
         inc = (win >= 0) && req_is_store_i[win];
         if (win >= 0) begin
            sb.push_back(req_i[win]);
            m_busy = 1'b1;
            m_ptr  = (win + 1) % N;
         end else if (m_busy && mlsu_req_ready_i) begin
            m_busy = 1'b0;
         end
         if (inc && !st_done_i) m_cnt++;
         else if (!inc && st_done_i) begin
            if (m_cnt > 0) m_cnt--;
            else m_err = 1'b1;
         end
      end
   endtask

   task automatic cycle(input logic rst, input logic [N-1:0] v, input logic [N-1:0] st,
                        input logic oe, input logic rdy, input logic done);
      @(negedge clk);
      rst_i            = rst;
      req_valid_i      = v;
      req_is_store_i   = st;
      order_en_i       = oe;
      mlsu_req_ready_i = rdy;
      st_done_i        = done;
      for (int i = 0; i < N; i++) req_i[i] = pay_t'($urandom);
      #2;
      model_step();
   endtask

   // Monitor: whenever a request is presented, it must match the oldest
   // scoreboard entry; the entry retires on the downstream handshake.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (mlsu_req_valid_o === 1'b1) begin
            if (sb.size() == 0) begin
               chk("sb_underrun", 32'(mlsu_req_valid_o), 32'd0);
            end else begin
               chk("payload", 32'(mlsu_req_o), 32'(sb[0]));
               if (mlsu_req_ready_i) void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      rst_i            = 1'b1;
      req_valid_i      = '0;
      req_is_store_i   = '0;
      order_en_i       = 1'b0;
      mlsu_req_ready_i = 1'b0;
      st_done_i        = 1'b0;
      for (int i = 0; i < N; i++) req_i[i] = 8'h00;

      // reset with requesters active: nothing may be accepted
      repeat (3) cycle(1'b1, 2'b11, 2'b01, 1'b0, 1'b1, 1'b0);

      // ordering: store from 0 blocks load from 1 until st_done
      cycle(1'b0, 2'b01, 2'b01, 1'b1, 1'b1, 1'b0);
      chk("ord_store_acc", 32'(req_ready_o), 32'd1);
      cycle(1'b0, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0);
      chk("ord_blocked",   32'(req_ready_o),       32'd0);
      chk("ord_pending",   32'(core_st_pending_o), 32'd1);
      chk("ord_cnt",       32'(st_cnt_o),          32'd1);
      cycle(1'b0, 2'b10, 2'b00, 1'b1, 1'b1, 1'b1);
      cycle(1'b0, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0);
      chk("ord_released",  32'(req_ready_o), 32'd2);
      cycle(1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);

      // store limit: third store stalls at count 2 until one completes
      repeat (6) cycle(1'b0, 2'b01, 2'b01, 1'b0, 1'b1, 1'b0);
      chk("lim_cnt",   32'(st_cnt_o),    32'd2);
      chk("lim_stall", 32'(req_ready_o), 32'd0);
      cycle(1'b0, 2'b01, 2'b01, 1'b0, 1'b1, 1'b1);
      cycle(1'b0, 2'b01, 2'b01, 1'b0, 1'b1, 1'b0);
      chk("lim_third", 32'(req_ready_o), 32'd1);

      // simultaneous inc/dec, then underflow
      cycle(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
      cycle(1'b0, 2'b01, 2'b01, 1'b0, 1'b1, 1'b1);
      cycle(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
      chk("incdec_cnt", 32'(st_cnt_o), 32'd1);
      cycle(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
      cycle(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
      cycle(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
      chk("uflow_err", 32'(err_o),    32'd1);
      chk("uflow_cnt", 32'(st_cnt_o), 32'd0);
      repeat (3) cycle(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
      chk("err_sticky", 32'(err_o), 32'd1);

      // alternating grants with two continuous loads
      repeat (2) cycle(1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
      for (int c = 0; c < 8; c++) begin
         cycle(1'b0, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0);
         chk("alternate", 32'(req_ready_o),
             (c % 2 != 0) ? 32'd0 : ((c % 4 == 0) ? 32'd1 : 32'd2));
      end

      // randomized traffic with occasional resets
      for (int c = 0; c < 2000; c++) begin
         cycle(($urandom_range(0, 249) == 0),
               N'($urandom), N'($urandom),
               ($urandom_range(0, 2) != 0),
               ($urandom_range(0, 9) < 7),
               ((m_cnt > 0) && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 199) == 0));
      end

      // long hold, then reset in the middle of it
      cycle(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
      repeat (5) cycle(1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
      chk("hold_cnt", 32'(st_cnt_o), 32'd1);
      #1;
      rst_i = 1'b1;
      #1;
      chk("midrst_valid", 32'(mlsu_req_valid_o), 32'd0);
      chk("midrst_cnt",   32'(st_cnt_o),         32'd0);
      model_reset();
      repeat (2) cycle(1'b1, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0);
      repeat (4) cycle(1'b0, 2'b11, 2'b10, 1'b1, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
